// File: rtl/sqrt_pipe_ctl_pkg.sv
// sqrt_pkg
// Shared definitions for the iterative square-root unit: the controller
// state encoding and the width/constant helpers derived from the operand
// width W.
// No ports (package).
package sqrt_pkg;

  // Controller states. DONE is a single cycle where the result is formatted.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WORK = 2'd1,
    DONE = 2'd2
  } state_e;

  // Root width for a W-bit operand.
  function automatic int rootWidth(input int w);
    return w / 2;
  endfunction

  // Iteration counter width; it must be able to hold the value R itself.
  function automatic int cntWidth(input int w);
    return $clog2(w / 2) + 1;
  endfunction

  // Starting bit-pair mask, 1 << (W-2). A wide return type keeps the helper
  // independent of W; callers take the low W bits.
  function automatic logic [127:0] initMask(input int w);
    return 128'(1) << (w - 2);
  endfunction

endpackage

// File: rtl/sqrt_pipe_ctl_step.sv
// sqrt_step
// One iteration of the bit-pair (restoring) square-root method, purely
// combinational so it can be reused in an unrolled pipeline later.
// Ports:
//   x_i / x_o : running remainder in / out (W bits)
//   y_i / y_o : partial root in / out (W bits)
//   m_i / m_o : bit-pair mask in / out (W bits)
module sqrt_step #(
  parameter int W = 16
) (
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic [W-1:0] m_i,
  output logic [W-1:0] x_o,
  output logic [W-1:0] y_o,
  output logic [W-1:0] m_o
);

  logic [W-1:0] trial;

  // Trial subtrahend for this bit position.
  assign trial = y_i | m_i;

  // If the trial value fits in the remainder, subtract it and set the root
  // bit; otherwise just shift the partial root down.
  always_comb begin
    x_o = x_i;
    y_o = y_i >> 1;
    if (x_i >= trial) begin
      x_o = x_i - trial;
      y_o = (y_i >> 1) | m_i;
    end
  end

  // The mask walks down one bit pair per iteration.
  assign m_o = m_i >> 2;

endmodule

// File: rtl/sqrt_pipe_ctl.sv
// sqrt_pipe_ctl
// Iterative integer square root: one result bit per clock, R = W/2 WORK
// cycles plus one DONE cycle. Produces floor or round-to-nearest root and
// the floor remainder, announced by a registered one-cycle valid pulse.
// Ports:
//   clk_i    : clock, rising edge
//   rst_i    : synchronous active-high reset
//   x_bi     : unsigned operand, sampled on accepted start
//   start_i  : start request, honoured only in IDLE
//   round_i  : 0 = floor, 1 = round to nearest, sampled with x_bi
//   busy_o   : high while an operation is in flight (WORK and DONE)
//   valid_o  : one-cycle pulse when y_bo / rem_bo carry a new result
//   y_bo     : root result (R bits)
//   rem_bo   : floor remainder x - floor(sqrt(x))^2 (R+1 bits)
module sqrt_pipe_ctl
  import sqrt_pkg::*;
#(
  parameter int W = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic [W-1:0]   x_bi,
  input  logic           start_i,
  input  logic           round_i,
  output logic           busy_o,
  output logic           valid_o,
  output logic [W/2-1:0] y_bo,
  output logic [W/2:0]   rem_bo
);

  localparam int R  = rootWidth(W);
  localparam int CW = cntWidth(W);
  localparam logic [127:0] InitMaskWide = initMask(W);
  localparam logic [W-1:0] InitMask = InitMaskWide[W-1:0];

  state_e         state_q, state_d;
  logic [W-1:0]   x_q, x_d;
  logic [W-1:0]   y_q, y_d;
  logic [W-1:0]   m_q, m_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           round_q, round_d;
  logic [R-1:0]   yOut_q, yOut_d;
  logic [R:0]     rem_q, rem_d;
  logic           valid_q, valid_d;

  logic [W-1:0]   xNext, yNext, mNext;
  logic [R-1:0]   floorRoot;
  logic [R:0]     remainder;
  logic           roundUp;
  logic [R-1:0]   finalRoot;

  sqrt_step #(.W(W)) u_step (
    .x_i (x_q),
    .y_i (y_q),
    .m_i (m_q),
    .x_o (xNext),
    .y_o (yNext),
    .m_o (mNext)
  );

  // Result formatting. Rounding up is needed when x > f^2 + f, i.e. the
  // remainder exceeds the floor root. An all-ones floor root cannot be
  // incremented, so it is left as is, which is exactly the saturated value.
  always_comb begin
    floorRoot = y_q[R-1:0];
    remainder = x_q[R:0];
    roundUp   = round_q && (remainder > {1'b0, floorRoot});
    finalRoot = floorRoot;
    if (roundUp && (floorRoot != '1)) begin
      finalRoot = floorRoot + R'(1);
    end
  end

  // Next-state and datapath control. Everything holds by default; start is
  // only looked at in IDLE, so requests during WORK/DONE are simply dropped.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    round_d = round_q;
    yOut_d  = yOut_q;
    rem_d   = rem_q;
    valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          x_d     = x_bi;
          round_d = round_i;
          y_d     = '0;
          m_d     = InitMask;
          cnt_d   = CW'(R);
          state_d = WORK;
        end
      end
      WORK: begin
        x_d   = xNext;
        y_d   = yNext;
        m_d   = mNext;
        cnt_d = cnt_q - CW'(1);
        // The counter, not the mask, decides when the iterations are done.
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        yOut_d  = finalRoot;
        rem_d   = remainder;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and data registers. Reset wins over any simultaneous start and
  // drops an in-flight operation without producing a result.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
      round_q <= 1'b0;
      yOut_q  <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
      yOut_q  <= yOut_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
    end
  end

  assign busy_o  = (state_q != IDLE);
  assign valid_o = valid_q;
  assign y_bo    = yOut_q;
  assign rem_bo  = rem_q;

endmodule
